// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, round constants and column/row helpers for the AES-128 core
package aes_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int ROUND_W = 4;

    // Entry n holds Rcon for round n; unused slots stay zero.
    localparam logic [15:0][7:0] RCON = {
        8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
        8'h36, 8'h1b, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
        8'h00
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_column(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Row r of column c takes the byte from column (c + r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8 * (4 * c + r) -: 8] = s[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box
module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] sub
);

    always_comb begin
        sub = 8'h00;
        case (data)
            8'h00: sub = 8'h63; 8'h01: sub = 8'h7c; 8'h02: sub = 8'h77; 8'h03: sub = 8'h7b; 8'h04: sub = 8'hf2; 8'h05: sub = 8'h6b; 8'h06: sub = 8'h6f; 8'h07: sub = 8'hc5;
            8'h08: sub = 8'h30; 8'h09: sub = 8'h01; 8'h0a: sub = 8'h67; 8'h0b: sub = 8'h2b; 8'h0c: sub = 8'hfe; 8'h0d: sub = 8'hd7; 8'h0e: sub = 8'hab; 8'h0f: sub = 8'h76;
            8'h10: sub = 8'hca; 8'h11: sub = 8'h82; 8'h12: sub = 8'hc9; 8'h13: sub = 8'h7d; 8'h14: sub = 8'hfa; 8'h15: sub = 8'h59; 8'h16: sub = 8'h47; 8'h17: sub = 8'hf0;
            8'h18: sub = 8'had; 8'h19: sub = 8'hd4; 8'h1a: sub = 8'ha2; 8'h1b: sub = 8'haf; 8'h1c: sub = 8'h9c; 8'h1d: sub = 8'ha4; 8'h1e: sub = 8'h72; 8'h1f: sub = 8'hc0;
            8'h20: sub = 8'hb7; 8'h21: sub = 8'hfd; 8'h22: sub = 8'h93; 8'h23: sub = 8'h26; 8'h24: sub = 8'h36; 8'h25: sub = 8'h3f; 8'h26: sub = 8'hf7; 8'h27: sub = 8'hcc;
            8'h28: sub = 8'h34; 8'h29: sub = 8'ha5; 8'h2a: sub = 8'he5; 8'h2b: sub = 8'hf1; 8'h2c: sub = 8'h71; 8'h2d: sub = 8'hd8; 8'h2e: sub = 8'h31; 8'h2f: sub = 8'h15;
            8'h30: sub = 8'h04; 8'h31: sub = 8'hc7; 8'h32: sub = 8'h23; 8'h33: sub = 8'hc3; 8'h34: sub = 8'h18; 8'h35: sub = 8'h96; 8'h36: sub = 8'h05; 8'h37: sub = 8'h9a;
            8'h38: sub = 8'h07; 8'h39: sub = 8'h12; 8'h3a: sub = 8'h80; 8'h3b: sub = 8'he2; 8'h3c: sub = 8'heb; 8'h3d: sub = 8'h27; 8'h3e: sub = 8'hb2; 8'h3f: sub = 8'h75;
            8'h40: sub = 8'h09; 8'h41: sub = 8'h83; 8'h42: sub = 8'h2c; 8'h43: sub = 8'h1a; 8'h44: sub = 8'h1b; 8'h45: sub = 8'h6e; 8'h46: sub = 8'h5a; 8'h47: sub = 8'ha0;
            8'h48: sub = 8'h52; 8'h49: sub = 8'h3b; 8'h4a: sub = 8'hd6; 8'h4b: sub = 8'hb3; 8'h4c: sub = 8'h29; 8'h4d: sub = 8'he3; 8'h4e: sub = 8'h2f; 8'h4f: sub = 8'h84;
            8'h50: sub = 8'h53; 8'h51: sub = 8'hd1; 8'h52: sub = 8'h00; 8'h53: sub = 8'hed; 8'h54: sub = 8'h20; 8'h55: sub = 8'hfc; 8'h56: sub = 8'hb1; 8'h57: sub = 8'h5b;
            8'h58: sub = 8'h6a; 8'h59: sub = 8'hcb; 8'h5a: sub = 8'hbe; 8'h5b: sub = 8'h39; 8'h5c: sub = 8'h4a; 8'h5d: sub = 8'h4c; 8'h5e: sub = 8'h58; 8'h5f: sub = 8'hcf;
            8'h60: sub = 8'hd0; 8'h61: sub = 8'hef; 8'h62: sub = 8'haa; 8'h63: sub = 8'hfb; 8'h64: sub = 8'h43; 8'h65: sub = 8'h4d; 8'h66: sub = 8'h33; 8'h67: sub = 8'h85;
            8'h68: sub = 8'h45; 8'h69: sub = 8'hf9; 8'h6a: sub = 8'h02; 8'h6b: sub = 8'h7f; 8'h6c: sub = 8'h50; 8'h6d: sub = 8'h3c; 8'h6e: sub = 8'h9f; 8'h6f: sub = 8'ha8;
            8'h70: sub = 8'h51; 8'h71: sub = 8'ha3; 8'h72: sub = 8'h40; 8'h73: sub = 8'h8f; 8'h74: sub = 8'h92; 8'h75: sub = 8'h9d; 8'h76: sub = 8'h38; 8'h77: sub = 8'hf5;
            8'h78: sub = 8'hbc; 8'h79: sub = 8'hb6; 8'h7a: sub = 8'hda; 8'h7b: sub = 8'h21; 8'h7c: sub = 8'h10; 8'h7d: sub = 8'hff; 8'h7e: sub = 8'hf3; 8'h7f: sub = 8'hd2;
            8'h80: sub = 8'hcd; 8'h81: sub = 8'h0c; 8'h82: sub = 8'h13; 8'h83: sub = 8'hec; 8'h84: sub = 8'h5f; 8'h85: sub = 8'h97; 8'h86: sub = 8'h44; 8'h87: sub = 8'h17;
            8'h88: sub = 8'hc4; 8'h89: sub = 8'ha7; 8'h8a: sub = 8'h7e; 8'h8b: sub = 8'h3d; 8'h8c: sub = 8'h64; 8'h8d: sub = 8'h5d; 8'h8e: sub = 8'h19; 8'h8f: sub = 8'h73;
            8'h90: sub = 8'h60; 8'h91: sub = 8'h81; 8'h92: sub = 8'h4f; 8'h93: sub = 8'hdc; 8'h94: sub = 8'h22; 8'h95: sub = 8'h2a; 8'h96: sub = 8'h90; 8'h97: sub = 8'h88;
            8'h98: sub = 8'h46; 8'h99: sub = 8'hee; 8'h9a: sub = 8'hb8; 8'h9b: sub = 8'h14; 8'h9c: sub = 8'hde; 8'h9d: sub = 8'h5e; 8'h9e: sub = 8'h0b; 8'h9f: sub = 8'hdb;
            8'ha0: sub = 8'he0; 8'ha1: sub = 8'h32; 8'ha2: sub = 8'h3a; 8'ha3: sub = 8'h0a; 8'ha4: sub = 8'h49; 8'ha5: sub = 8'h06; 8'ha6: sub = 8'h24; 8'ha7: sub = 8'h5c;
            8'ha8: sub = 8'hc2; 8'ha9: sub = 8'hd3; 8'haa: sub = 8'hac; 8'hab: sub = 8'h62; 8'hac: sub = 8'h91; 8'had: sub = 8'h95; 8'hae: sub = 8'he4; 8'haf: sub = 8'h79;
            8'hb0: sub = 8'he7; 8'hb1: sub = 8'hc8; 8'hb2: sub = 8'h37; 8'hb3: sub = 8'h6d; 8'hb4: sub = 8'h8d; 8'hb5: sub = 8'hd5; 8'hb6: sub = 8'h4e; 8'hb7: sub = 8'ha9;
            8'hb8: sub = 8'h6c; 8'hb9: sub = 8'h56; 8'hba: sub = 8'hf4; 8'hbb: sub = 8'hea; 8'hbc: sub = 8'h65; 8'hbd: sub = 8'h7a; 8'hbe: sub = 8'hae; 8'hbf: sub = 8'h08;
            8'hc0: sub = 8'hba; 8'hc1: sub = 8'h78; 8'hc2: sub = 8'h25; 8'hc3: sub = 8'h2e; 8'hc4: sub = 8'h1c; 8'hc5: sub = 8'ha6; 8'hc6: sub = 8'hb4; 8'hc7: sub = 8'hc6;
            8'hc8: sub = 8'he8; 8'hc9: sub = 8'hdd; 8'hca: sub = 8'h74; 8'hcb: sub = 8'h1f; 8'hcc: sub = 8'h4b; 8'hcd: sub = 8'hbd; 8'hce: sub = 8'h8b; 8'hcf: sub = 8'h8a;
            8'hd0: sub = 8'h70; 8'hd1: sub = 8'h3e; 8'hd2: sub = 8'hb5; 8'hd3: sub = 8'h66; 8'hd4: sub = 8'h48; 8'hd5: sub = 8'h03; 8'hd6: sub = 8'hf6; 8'hd7: sub = 8'h0e;
            8'hd8: sub = 8'h61; 8'hd9: sub = 8'h35; 8'hda: sub = 8'h57; 8'hdb: sub = 8'hb9; 8'hdc: sub = 8'h86; 8'hdd: sub = 8'hc1; 8'hde: sub = 8'h1d; 8'hdf: sub = 8'h9e;
            8'he0: sub = 8'he1; 8'he1: sub = 8'hf8; 8'he2: sub = 8'h98; 8'he3: sub = 8'h11; 8'he4: sub = 8'h69; 8'he5: sub = 8'hd9; 8'he6: sub = 8'h8e; 8'he7: sub = 8'h94;
            8'he8: sub = 8'h9b; 8'he9: sub = 8'h1e; 8'hea: sub = 8'h87; 8'heb: sub = 8'he9; 8'hec: sub = 8'hce; 8'hed: sub = 8'h55; 8'hee: sub = 8'h28; 8'hef: sub = 8'hdf;
            8'hf0: sub = 8'h8c; 8'hf1: sub = 8'ha1; 8'hf2: sub = 8'h89; 8'hf3: sub = 8'h0d; 8'hf4: sub = 8'hbf; 8'hf5: sub = 8'he6; 8'hf6: sub = 8'h42; 8'hf7: sub = 8'h68;
            8'hf8: sub = 8'h41; 8'hf9: sub = 8'h99; 8'hfa: sub = 8'h2d; 8'hfb: sub = 8'h0f; 8'hfc: sub = 8'hb0; 8'hfd: sub = 8'h54; 8'hfe: sub = 8'hbb; 8'hff: sub = 8'h16;
            default: sub = 8'h00;
        endcase
    end

endmodule

// File: rtl/aes.sv
// rtl/aes.sv - iterative AES-128 encryption core, one round per clock with on-the-fly key expansion
module aes
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic [127:0] plain_text,
    input  logic [127:0] key,
    output logic         done,
    output logic [127:0] cipher_text
);

    state_t               fsm;
    logic [ROUND_W-1:0]   round;
    logic [127:0]         state_q;
    logic [127:0]         round_key;
    logic [127:0]         sub_out;
    logic [127:0]         shifted;
    logic [127:0]         mixed;
    logic [127:0]         next_key;
    logic [127:0]         round_out;
    logic [31:0]          rot_word;
    logic [31:0]          sub_word;
    logic [31:0]          temp_word;

    for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
        aes_sbox u_sbox (.data(state_q[127 - 8 * i -: 8]), .sub(sub_out[127 - 8 * i -: 8]));
    end

    // SubWord(RotWord(w3)): w3 is the last word of the current round key.
    assign rot_word = {round_key[23:0], round_key[31:24]};
    for (genvar i = 0; i < 4; i++) begin : g_sub_word
        aes_sbox u_sbox (.data(rot_word[31 - 8 * i -: 8]), .sub(sub_word[31 - 8 * i -: 8]));
    end

    assign temp_word        = sub_word ^ {RCON[round], 24'h000000};
    assign next_key[127:96] = round_key[127:96] ^ temp_word;
    assign next_key[95:64]  = round_key[95:64]  ^ next_key[127:96];
    assign next_key[63:32]  = round_key[63:32]  ^ next_key[95:64];
    assign next_key[31:0]   = round_key[31:0]   ^ next_key[63:32];

    assign shifted = shift_rows(sub_out);
    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mixed[127 - 32 * c -: 32] = mix_column(shifted[127 - 32 * c -: 32]);
    end

    assign round_out = ((round == ROUND_W'(10)) ? shifted : mixed) ^ next_key;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= IDLE;
            done        <= 1'b0;
            cipher_text <= '0;
            round       <= '0;
            state_q     <= '0;
            round_key   <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (enable) begin
                        state_q   <= plain_text ^ key;
                        round_key <= key;
                        round     <= ROUND_W'(1);
                        fsm       <= RUN;
                    end
                end
                RUN: begin
                    state_q   <= round_out;
                    round_key <= next_key;
                    round     <= round + ROUND_W'(1);
                    if (round == ROUND_W'(10)) begin
                        cipher_text <= round_out;
                        done        <= 1'b1;
                        fsm         <= DONE;
                    end
                end
                DONE: begin
                    if (!enable) begin
                        done <= 1'b0;
                        fsm  <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes.sv
// tb/tb_aes.sv - self-checking bench for the AES-128 core using known-answer vectors and a result scoreboard
module tb_aes;

    logic         clk;
    logic         rst;
    logic         enable;
    logic [127:0] plain_text;
    logic [127:0] key;
    logic         done;
    logic [127:0] cipher_text;

    aes dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .plain_text (plain_text),
        .key        (key),
        .done       (done),
        .cipher_text(cipher_text)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] pt;
        logic [127:0] k;
        logic [127:0] ct;
    } vec_t;

    vec_t         vecs[3];
    logic [127:0] sb[$];
    logic [127:0] last_ct;
    int           checks;
    int           errors;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic start_block(input vec_t v);
        @(negedge clk);
        plain_text = v.pt;
        key        = v.k;
        enable     = 1'b1;
        sb.push_back(v.ct);
    endtask

    // Counts edges from the start edge until done, optionally scrambling inputs mid-run.
    task automatic wait_done(input string name, input int scramble_at);
        int n;
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (n == scramble_at) begin
                plain_text = {$urandom, $urandom, $urandom, $urandom};
                key        = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        check({name, "_latency"}, 128'(n), 128'd11);
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_scoreboard actual=empty required=entry", name);
        end else begin
            last_ct = sb.pop_front();
            check({name, "_ct"}, cipher_text, last_ct);
        end
    endtask

    task automatic drop_enable(input string name);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_done_fall"}, 128'(done), 128'd0);
        check({name, "_ct_kept"}, cipher_text, last_ct);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        last_ct = '0;
        vecs[0] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{128'h54776f204f6e65204e696e652054776f, 128'h5468617473206d79204b756e67204675,
                    128'h29c3505f571420f6402299b31a02d73a};

        rst        = 1'b1;
        enable     = 1'b1;
        plain_text = vecs[0].pt;
        key        = vecs[0].k;
        repeat (2) begin
            @(posedge clk);
            #1;
            check("reset_done", 128'(done), 128'd0);
            check("reset_ct", cipher_text, 128'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(vecs[0].ct);
        wait_done("post_reset", 0);
        drop_enable("post_reset");

        for (int i = 0; i < 3; i++) begin
            start_block(vecs[i]);
            wait_done($sformatf("vec%0d", i), 0);
            drop_enable($sformatf("vec%0d", i));
        end

        start_block(vecs[2]);
        wait_done("hold", 0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            check("hold_done", 128'(done), 128'd1);
            check("hold_ct", cipher_text, vecs[2].ct);
        end
        drop_enable("hold");

        start_block(vecs[1]);
        wait_done("midrun", 3);
        drop_enable("midrun");
        start_block(vecs[0]);
        wait_done("second", 0);
        drop_enable("second");

        @(negedge clk);
        plain_text = vecs[1].pt;
        key        = vecs[1].k;
        enable     = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("abort_done", 128'(done), 128'd0);
        check("abort_ct", cipher_text, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            check("abort_idle_done", 128'(done), 128'd0);
        end
        last_ct = '0;
        start_block(vecs[1]);
        wait_done("after_abort", 0);
        drop_enable("after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes.md
# aes

Iterative AES-128 encryption core (FIPS-197), one round per clock. Accepts a 128-bit plaintext and 128-bit key on a level-sensitive `enable`, expands round keys on the fly, and presents the 128-bit ciphertext with a `done` flag. Used as a standalone encryption datapath; no decryption.

## Interface
- No parameters; the key size is fixed at 128 bits and the round count at 10.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  start request; level-sensitive, sampled only in IDLE
- plain_text  in  128  plaintext block; bits [127:120] = byte 0
- key  in  128  cipher key; bits [127:120] = byte 0
- done  out  1  high while cipher_text holds a completed result
- cipher_text  out  128  ciphertext, registered

## Operation
- Byte order follows FIPS-197: byte i = bits [127-8i -: 8]; state is column-major (bytes 0-3 form column 0).
- FSM states and transitions:
  - IDLE → RUN when enable=1. On that edge: state register ← plain_text ^ key; round_key ← key; round ← 1.
  - RUN: each cycle applies SubBytes, ShiftRows, MixColumns (omitted when round=10), then AddRoundKey with next_key. Also: round_key ← next_key, round ← round+1.
    - next_key = KeyExpansion(round_key, Rcon[round]).
    - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
  - RUN → DONE on the round-10 edge. On that edge: cipher_text ← round-10 output; done ← 1.
  - DONE holds done=1 and cipher_text stable while enable=1. When enable=0, go to IDLE and set done ← 0.
- cipher_text keeps its last value in IDLE and RUN until the next completion overwrites it.
- plain_text, key and enable changes during RUN are ignored; inputs are captured only on the IDLE→RUN edge.
- MixColumns uses GF(2^8) with the polynomial 0x11B (xtime: shift left, then XOR 0x1B if bit 7 was set).

## Timing
- Reset (rst=1 at an edge): FSM → IDLE, done=0, cipher_text=0, round=0. This applies from any state; a reset mid-RUN aborts the operation with no output.
- Latency: edge E0 samples enable=1 in IDLE. Rounds 1-10 execute on edges E1..E10. done=1 and cipher_text are valid after E10, i.e. 10 cycles after the start edge and 11 edges after enable is first seen.
- enable held high continuously: the core completes exactly once and stays in DONE. A new encryption needs enable low for at least one cycle (DONE→IDLE), then high again.
- Back-to-back throughput: one block per 12 cycles (start, 10 rounds, 1 idle).
- rst and enable high at the same edge: reset wins.
- Everything is synchronous to clk; there are no combinational paths from inputs to outputs.

## Structure
- Package `aes_pkg` contains:
  - FSM state enum (IDLE, RUN, DONE)
  - Rcon constant array
  - functions xtime, mix_column, shift_rows
  - round-counter width (4 bits)
- Sub-module `aes_sbox` is a combinational 8-bit → 8-bit forward S-box lookup (256-entry case). Instantiate it 20×: 16 for SubBytes, 4 for the key schedule's SubWord(RotWord(w3)).
- The top level `aes` holds the FSM, the state/round_key/round/cipher_text registers, and the round and key-expansion combinational logic.

## Test plan
- Reset: assert rst for 2 cycles with enable=1 → done=0, cipher_text=0 throughout. Release rst → the core starts on the next edge.
- FIPS-197 App. B: pt 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → cipher_text 3925841d02dc09fbdc118597196a0b32, done rises exactly 10 cycles after the start edge.
- FIPS-197 App. C.1: pt 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → 69c4e0d86a7b0430d8cdb78070b4c55a.
- Hold enable=1 for 40 cycles: pt 54776f204f6e65204e696e652054776f, key 5468617473206d79204b756e67204675 → cipher_text 29c3505f571420f6402299b31a02d73a, done stays 1 and the core never restarts.
- Change plain_text/key mid-RUN, then drop enable after done, then start a second block → the first result is unaffected by the mid-RUN change, done falls one cycle after enable=0, and the second result is correct.
- Pulse rst at round 5 → done stays 0 and cipher_text=0. A fresh start after that completes correctly.
